// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-requester arbiter in front of a single shared RAM, with
//            ERROR retry and a BUSY watchdog.
// Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int MAX_RETRY   = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_ren_i,
    input  logic        p0_wen_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_store_i,
    output logic        p0_wait_o,
    output logic [31:0] p0_load_o,
    output logic        p0_err_o,
    input  logic        p1_ren_i,
    input  logic        p1_wen_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_store_i,
    output logic        p1_wait_o,
    output logic [31:0] p1_load_o,
    output logic        p1_err_o,
    output logic        ram_ren_o,
    output logic        ram_wen_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_store_o,
    input  logic [1:0]  ram_state_i,
    input  logic [31:0] ram_load_i
);
    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;
    localparam int c_RW = $clog2(MAX_RETRY + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t            state_q;
    logic              grant_q;
    logic              prio_q;
    logic              ram_ren_q;
    logic              ram_wen_q;
    logic [31:0]       ram_addr_q;
    logic [31:0]       ram_store_q;
    logic [c_RW-1:0]   retry_q;
    logic [c_TW-1:0]   tmo_q;

    logic w_req0, w_req1, w_win, w_busy, w_stall;
    logic w_access, w_err_term, w_tmo_term, w_abort, w_done;

    assign w_req0 = p0_ren_i | p0_wen_i;
    assign w_req1 = p1_ren_i | p1_wen_i;
    // A sole requester wins outright; a contested cycle goes to the priority port.
    assign w_win  = (w_req0 & w_req1) ? prio_q : w_req1;

    assign w_busy     = (state_q == ST_BUSY);
    assign w_stall    = (ram_state_i == c_FREE) || (ram_state_i == c_BUSY);
    assign w_access   = w_busy && (ram_state_i == c_ACCESS);
    assign w_err_term = w_busy && (ram_state_i == c_ERROR) &&
                        (retry_q == c_RW'(MAX_RETRY - 1));
    assign w_tmo_term = w_busy && w_stall && (tmo_q == c_TW'(TIMEOUT - 1));
    assign w_abort    = w_err_term | w_tmo_term;
    assign w_done     = w_access | w_abort;

    assign p0_wait_o = ~(w_done & ~grant_q);
    assign p1_wait_o = ~(w_done &  grant_q);
    assign p0_err_o  = w_abort & ~grant_q;
    assign p1_err_o  = w_abort &  grant_q;
    assign p0_load_o = (w_access & ~grant_q & ram_ren_q) ? ram_load_i : 32'd0;
    assign p1_load_o = (w_access &  grant_q & ram_ren_q) ? ram_load_i : 32'd0;

    assign ram_ren_o   = ram_ren_q;
    assign ram_wen_o   = ram_wen_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_store_o = ram_store_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_store_q <= 32'd0;
            retry_q     <= '0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        state_q     <= ST_BUSY;
                        grant_q     <= w_win;
                        // A write request overrides a simultaneous read.
                        ram_wen_q   <= w_win ? p1_wen_i : p0_wen_i;
                        ram_ren_q   <= w_win ? (p1_ren_i & ~p1_wen_i)
                                             : (p0_ren_i & ~p0_wen_i);
                        ram_addr_q  <= w_win ? p1_addr_i  : p0_addr_i;
                        ram_store_q <= w_win ? p1_store_i : p0_store_i;
                        retry_q     <= '0;
                        tmo_q       <= '0;
                        if (ROUND_ROBIN && w_req0 && w_req1) begin
                            prio_q <= ~w_win;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        state_q   <= ST_IDLE;
                        ram_ren_q <= 1'b0;
                        ram_wen_q <= 1'b0;
                    end else if (ram_state_i == c_ERROR) begin
                        retry_q <= retry_q + 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
